// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
//   state_e       : round sequencer states (also exported for debug)
//   LFSR_*        : hole-selection LFSR width, feedback taps and default seed
//   onehot4       : 2-bit hole index -> 4-bit mole mask
//   sat_inc4      : 4-bit counter increment that sticks at 15
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int          LFSR_W        = 4;
  localparam int          LFSR_TAP_A    = 3;
  localparam int          LFSR_TAP_B    = 2;
  localparam logic [3:0]  LFSR_SEED_DEF = 4'b1001;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    sat_inc4 = (val == 4'hF) ? val : val + 4'd1;
  endfunction

endpackage

// File: rtl/mole_game_ctrl_if.sv
// Player/display bundle of the whack-a-mole sequencer.
//   start, btn                         : player side inputs (driven by master)
//   mole, score, misses, busy, done    : display side outputs (driven by slave)
//   dbg_state                          : current sequencer state, for checkers
// Handshake: there is no valid/ready pair here. start is a level sampled on
// every rising edge while the sequencer is in IDLE or DONE and ignored
// otherwise; btn is sampled every edge and only its rising edges count.
interface mole_game_ctrl_if;
  import mole_pkg::*;

  logic       start;
  logic [3:0] btn;
  logic [3:0] mole;
  logic [3:0] score;
  logic [3:0] misses;
  logic       busy;
  logic       done;
  state_e     dbg_state;

  modport master (
    output start, btn,
    input  mole, score, misses, busy, done, dbg_state
  );

  modport slave (
    input  start, btn,
    output mole, score, misses, busy, done, dbg_state
  );

endinterface

// File: rtl/mole_lfsr.sv
// 4-bit Fibonacci LFSR choosing the hole for each round.
//   clk, rst_n : clock, async active-low reset (reset loads SEED)
//   load_i     : reload SEED (new game)
//   step_i     : advance one step (a mole is being raised)
//   sel_o      : low two bits of the current value = hole index
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  output logic [1:0] sel_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift left, feeding back the XOR of the two top taps.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sel_o = lfsr_q[1:0];

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: raises one pseudo-randomly chosen mole per
// round, opens a fixed hit window, judges button rising edges against it and
// keeps saturating score/miss totals over ROUNDS rounds.
//   clk, rst_n : clock, async active-low reset
//   bus        : mole_game_ctrl_if.slave (start/btn in; mole, score, misses,
//                busy, done, dbg_state out -- all outputs registered)
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int               UP_CYCLES  = 8,
  parameter int               GAP_CYCLES = 4,
  parameter int               ROUNDS     = 15,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mole_game_ctrl_if.slave   bus
);

  state_e     state_q;
  logic [7:0] timer_q;
  logic [3:0] round_q;
  logic [3:0] btn_q;
  logic [3:0] mole_q;
  logic [3:0] score_q;
  logic [3:0] misses_q;
  logic       busy_q;
  logic       done_q;

  logic [1:0] sel;
  logic [3:0] rise;
  logic       wrong;
  logic       hit;
  logic       timeout;
  logic       start_ok;
  logic       raise;
  logic [3:0] round_d;

  assign rise     = bus.btn & ~btn_q;
  // In UP the mole register holds onehot(sel), so it doubles as the hole mask.
  assign wrong    = |(rise & ~mole_q);
  assign hit      = |(rise & mole_q);
  assign timeout  = (timer_q == 8'd0);
  assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign raise    = (state_q == GAP) && (timer_q == 8'd0);
  assign round_d  = round_q + 4'd1;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_ok),
    .step_i (raise),
    .sel_o  (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= 8'd0;
      round_q  <= 4'd0;
      btn_q    <= 4'd0;
      mole_q   <= 4'd0;
      score_q  <= 4'd0;
      misses_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      btn_q <= bus.btn;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q  <= GAP;
            timer_q  <= 8'(GAP_CYCLES - 1);
            round_q  <= 4'd0;
            score_q  <= 4'd0;
            misses_q <= 4'd0;
            mole_q   <= 4'd0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        GAP: begin
          if (!timeout) begin
            timer_q <= timer_q - 8'd1;
          end else begin
            state_q <= UP;
            mole_q  <= onehot4(sel);
            timer_q <= 8'(UP_CYCLES - 1);
          end
        end
        UP: begin
          if (wrong || hit || timeout) begin
            // A wrong bit beats a correct one pressed in the same cycle.
            if (hit && !wrong) begin
              score_q <= sat_inc4(score_q);
            end else begin
              misses_q <= sat_inc4(misses_q);
            end
            mole_q  <= 4'd0;
            round_q <= round_d;
            if (round_d == 4'(ROUNDS)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= GAP;
              timer_q <= 8'(GAP_CYCLES - 1);
            end
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mole      = mole_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Testbench for mole_game_ctrl: directed game scenarios with literal
// expectations plus a round-level game model checked every falling edge.
module tb_mole_game_ctrl;
  import mole_pkg::*;

  localparam int UP_N  = 8;
  localparam int GAP_N = 4;
  localparam int RND_N = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   check_en = 1'b0;

  mole_game_ctrl_if bus();

  mole_game_ctrl #(
    .UP_CYCLES  (UP_N),
    .GAP_CYCLES (GAP_N),
    .ROUNDS     (RND_N),
    .LFSR_SEED  (4'b1001)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- game model ----------------
  // Phase of play (0 idle, 1 gap, 2 up, 3 done) plus cycles spent in it.
  int         m_phase = 0;
  int         m_age = 0;
  int         m_round = 0;
  logic [3:0] m_score = 4'd0;
  logic [3:0] m_miss = 4'd0;
  logic [3:0] m_prev_btn = 4'd0;
  int         holes[16];

  function automatic logic [3:0] m_mask();
    return (m_phase == 2) ? (4'b0001 << holes[m_round]) : 4'd0;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_age = 0; m_round = 0;
    m_score = 4'd0; m_miss = 4'd0; m_prev_btn = 4'd0;
  endtask

  task automatic m_end_round();
    m_round = m_round + 1;
    m_age = 0;
    m_phase = (m_round == RND_N) ? 3 : 1;
  endtask

  task automatic m_step();
    logic [3:0] rise;
    logic [3:0] mask;
    rise = bus.btn & ~m_prev_btn;
    m_prev_btn = bus.btn;
    mask = m_mask();
    case (m_phase)
      0, 3: if (bus.start) begin
        m_phase = 1; m_age = 0; m_round = 0; m_score = 4'd0; m_miss = 4'd0;
      end
      1: if (m_age == GAP_N - 1) begin m_phase = 2; m_age = 0; end
         else m_age = m_age + 1;
      default: begin
        if ((rise & ~mask) != 4'd0) begin
          if (m_miss != 4'hF) m_miss = m_miss + 4'd1;
          m_end_round();
        end else if ((rise & mask) != 4'd0) begin
          if (m_score != 4'hF) m_score = m_score + 4'd1;
          m_end_round();
        end else if (m_age == UP_N - 1) begin
          if (m_miss != 4'hF) m_miss = m_miss + 4'd1;
          m_end_round();
        end else m_age = m_age + 1;
      end
    endcase
  endtask

  initial begin
    logic [3:0] l;
    l = 4'b1001;
    for (int r = 0; r < 16; r++) begin
      holes[r] = int'(l[1:0]);
      l = {l[2:0], l[3] ^ l[2]};
    end
  end

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("mdl_mole",   8'(bus.mole),   8'(m_mask()));
        chk("mdl_score",  8'(bus.score),  8'(m_score));
        chk("mdl_misses", 8'(bus.misses), 8'(m_miss));
        chk("mdl_busy",   8'(bus.busy),   8'((m_phase == 1) || (m_phase == 2)));
        chk("mdl_done",   8'(bus.done),   8'(m_phase == 3));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns 1ns after the edge E that samples start=1.
  task automatic start_pulse();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_mole();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step_n(1);
      if (bus.mole != 4'd0) seen = 1'b1;
    end
    chk("mole_wait", 8'(seen), 8'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.start = 1'b0;
    bus.btn = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    step_n(20);
    chk("idle_busy", 8'(bus.busy), 8'd0);
    chk("idle_state", 8'(bus.dbg_state), 8'(IDLE));

    // First round timeout, second mole
    start_pulse();
    chk("busy_after_start", 8'(bus.busy), 8'd1);
    step_n(3);
    chk("to_mole_e3", 8'(bus.mole), 8'd0);
    step_n(1);
    chk("to_mole_e4", 8'(bus.mole), 8'b0010);
    step_n(7);
    chk("to_mole_e11", 8'(bus.mole), 8'b0010);
    step_n(1);
    chk("to_mole_e12", 8'(bus.mole), 8'd0);
    chk("to_misses", 8'(bus.misses), 8'd1);
    step_n(4);
    chk("to_mole2_e16", 8'(bus.mole), 8'b1000);
    do_reset();

    // Hit in round 1, with a stray start in GAP that must be ignored
    start_pulse();
    bus.start = 1'b1;
    step_n(1);
    bus.start = 1'b0;
    step_n(5);
    bus.btn = 4'b0010;
    step_n(1);
    chk("hit_score", 8'(bus.score), 8'd1);
    chk("hit_mole", 8'(bus.mole), 8'd0);
    chk("hit_misses", 8'(bus.misses), 8'd0);
    bus.btn = 4'd0;
    do_reset();

    // Wrong + correct bit together
    start_pulse();
    step_n(6);
    bus.btn = 4'b0011;
    step_n(1);
    chk("wrong_misses", 8'(bus.misses), 8'd1);
    chk("wrong_score", 8'(bus.score), 8'd0);
    bus.btn = 4'd0;
    do_reset();

    // Button held from GAP into UP gives no hit
    start_pulse();
    step_n(1);
    bus.btn = 4'b0010;
    step_n(10);
    chk("held_mole_e11", 8'(bus.mole), 8'b0010);
    step_n(1);
    chk("held_mole_e12", 8'(bus.mole), 8'd0);
    chk("held_misses", 8'(bus.misses), 8'd1);
    chk("held_score", 8'(bus.score), 8'd0);
    bus.btn = 4'd0;
    do_reset();

    // Full game, correct hole every round, then restart from DONE
    start_pulse();
    for (int r = 0; r < RND_N; r++) begin
      wait_mole();
      bus.btn = bus.mole;
      step_n(1);
      bus.btn = 4'd0;
    end
    chk("full_done", 8'(bus.done), 8'd1);
    chk("full_score", 8'(bus.score), 8'd15);
    chk("full_busy", 8'(bus.busy), 8'd0);
    chk("full_misses", 8'(bus.misses), 8'd0);
    step_n(3);
    chk("full_done_held", 8'(bus.done), 8'd1);
    start_pulse();
    chk("restart_score", 8'(bus.score), 8'd0);
    chk("restart_done", 8'(bus.done), 8'd0);
    step_n(4);
    chk("restart_mole", 8'(bus.mole), 8'b0010);

    // Async reset mid hit window
    step_n(2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mole", 8'(bus.mole), 8'd0);
    chk("arst_busy", 8'(bus.busy), 8'd0);
    chk("arst_state", 8'(bus.dbg_state), 8'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    start_pulse();
    step_n(4);
    chk("arst_first_hole", 8'(bus.mole), 8'b0010);

    step_n(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
